// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: arbitrates the core's inst (fetch, read-only) and data
// (load/store) SRAM-like masters onto a single AXI3 master port.
// At most one read and one write are in flight at any time.
// Constant AXI fields (len, burst, lock, cache, prot, wid, wlast) are tied
// off by the wrapper and do not appear here.
// Optional feature macro: RAW_CHECK_EN -- holds a data read whose word
// address matches the write still in flight, until that write completes.
//
// state   | meaning
// --------+---------------------------------------------------------------
// R_IDLE  | no read in flight; arbitrate data read over inst read
// R_AR    | arvalid high with latched addr/size/id, waiting for arready
// R_DATA  | rready high, waiting for rvalid; data_ok routed by rid
// W_IDLE  | no write in flight; accept a data write
// W_REQ   | awvalid/wvalid high, each dropping after its own handshake
// W_RESP  | bready high (unless a data read returns this cycle), wait bvalid

module cpu_axi_bridge #(
    parameter logic [3:0] ID_INST = 4'd0,
    parameter logic [3:0] ID_DATA = 4'd1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,

    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,

    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_REQ, W_RESP} w_state_e;

    r_state_e    r_state_q, r_state_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [1:0]  rd_size_q, rd_size_d;
    logic [3:0]  rd_id_q,   rd_id_d;

    w_state_e    w_state_q, w_state_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q,  w_done_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [1:0]  wr_size_q, wr_size_d;
    logic [3:0]  wr_strb_q, wr_strb_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic data_rd_req;
    logic raw_hold;
    logic rd_data_go;
    logic rd_inst_go;
    logic wr_go;
    logic r_fire;
    logic rd_collide;
    logic b_fire;
    logic aw_hs;
    logic w_hs;

    // Request arbitration and channel handshake decode for the current cycle.
    always_comb begin
        data_rd_req = data_req & ~data_wr;
`ifdef RAW_CHECK_EN
        // Keep program order: a read to the word still being written waits,
        // and the inst master is held off behind it.
        raw_hold = data_rd_req & (w_state_q != W_IDLE) &
                   (data_addr[31:2] == wr_addr_q[31:2]);
`else
        raw_hold = 1'b0;
`endif
        rd_data_go = (r_state_q == R_IDLE) & data_rd_req & ~raw_hold;
        // A pending data read always beats fetch, even while it is held.
        rd_inst_go = (r_state_q == R_IDLE) & inst_req & ~data_rd_req;
        wr_go      = (w_state_q == W_IDLE) & data_req & data_wr;
        r_fire     = (r_state_q == R_DATA) & rvalid;
        // A returning data read takes the single data_data_ok slot first.
        rd_collide = r_fire & (rid == ID_DATA);
        b_fire     = (w_state_q == W_RESP) & bvalid & ~rd_collide;
        aw_hs      = (w_state_q == W_REQ) & ~aw_done_q & awready;
        w_hs       = (w_state_q == W_REQ) & ~w_done_q & wready;
    end

    // Read FSM next state and request latching.
    always_comb begin
        r_state_d = r_state_q;
        rd_addr_d = rd_addr_q;
        rd_size_d = rd_size_q;
        rd_id_d   = rd_id_q;
        case (r_state_q)
            R_IDLE: begin
                if (rd_data_go) begin
                    rd_addr_d = data_addr;
                    rd_size_d = data_size;
                    rd_id_d   = ID_DATA;
                    r_state_d = R_AR;
                end else if (rd_inst_go) begin
                    rd_addr_d = inst_addr;
                    rd_size_d = inst_size;
                    rd_id_d   = ID_INST;
                    r_state_d = R_AR;
                end
            end
            R_AR: begin
                if (arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                if (rvalid) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write FSM next state; AW and W complete independently in W_REQ.
    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        wr_addr_d = wr_addr_q;
        wr_size_d = wr_size_q;
        wr_strb_d = wr_strb_q;
        wr_data_d = wr_data_q;
        case (w_state_q)
            W_IDLE: begin
                if (wr_go) begin
                    wr_addr_d = data_addr;
                    wr_size_d = data_size;
                    wr_strb_d = data_wstrb;
                    wr_data_d = data_wdata;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_REQ;
                end
            end
            W_REQ: begin
                aw_done_d = aw_done_q | aw_hs;
                w_done_d  = w_done_q | w_hs;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_fire) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // State and latched request registers; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            rd_addr_q <= '0;
            rd_size_q <= '0;
            rd_id_q   <= '0;
            w_state_q <= W_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_size_q <= '0;
            wr_strb_q <= '0;
            wr_data_q <= '0;
        end else begin
            r_state_q <= r_state_d;
            rd_addr_q <= rd_addr_d;
            rd_size_q <= rd_size_d;
            rd_id_q   <= rd_id_d;
            w_state_q <= w_state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            wr_addr_q <= wr_addr_d;
            wr_size_q <= wr_size_d;
            wr_strb_q <= wr_strb_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Control outputs are forced low while reset is held.
    assign inst_addr_ok = ~reset & rd_inst_go;
    assign data_addr_ok = ~reset & (rd_data_go | wr_go);
    assign inst_data_ok = ~reset & r_fire & (rid == ID_INST);
    assign data_data_ok = ~reset & (rd_collide | b_fire);
    assign inst_rdata   = rdata;
    assign data_rdata   = rdata;

    assign arid    = rd_id_q;
    assign araddr  = rd_addr_q;
    assign arsize  = {1'b0, rd_size_q};
    assign arvalid = ~reset & (r_state_q == R_AR);
    assign rready  = ~reset & (r_state_q == R_DATA);

    assign awid    = ID_DATA;
    assign awaddr  = wr_addr_q;
    assign awsize  = {1'b0, wr_size_q};
    assign awvalid = ~reset & (w_state_q == W_REQ) & ~aw_done_q;
    assign wdata   = wr_data_q;
    assign wstrb   = wr_strb_q;
    assign wvalid  = ~reset & (w_state_q == W_REQ) & ~w_done_q;
    assign bready  = ~reset & (w_state_q == W_RESP) & ~rd_collide;

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Testbench for cpu_axi_bridge: per-cycle stimulus/expectation rows plus a
// scoreboard for AR/AW/W channel contents.
module tb_cpu_axi_bridge;

    localparam logic [3:0]  ID_INST = 4'd0;
    localparam logic [3:0]  ID_DATA = 4'd1;
    localparam logic [31:0] IADDR   = 32'h1c00_0000;
    localparam logic [31:0] WDATA   = 32'h0000_1234;
    localparam logic [3:0]  WSTRB   = 4'hF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        inst_req = 1'b0;
    logic [1:0]  inst_size = 2'd2;
    logic [31:0] inst_addr = IADDR;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'd0;
    logic [3:0]  data_wstrb = WSTRB;
    logic [31:0] data_addr = '0, data_wdata = WDATA;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid, arready = 1'b0;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid, awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid, wready = 1'b0;
    logic        bvalid = 1'b0, bready;

    always #5 clk = ~clk;

    cpu_axi_bridge #(.ID_INST(ID_INST), .ID_DATA(ID_DATA)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic        dreq;
        logic        dwr;
        logic [1:0]  dsize;
        logic [31:0] daddr;
        logic        arready;
        logic        rvalid;
        logic [3:0]  rid;
        logic [31:0] rdata;
        logic        awready;
        logic        wready;
        logic        bvalid;
        logic        e_iaok;
        logic        e_daok;
        logic        e_arvalid;
        logic        e_rready;
        logic        e_idok;
        logic        e_ddok;
        logic        e_awvalid;
        logic        e_wvalid;
        logic        e_bready;
    } row_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_exp_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
    } aw_exp_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_exp_t;

    row_t    tbl[$];
    ar_exp_t ar_q[$];
    aw_exp_t aw_q[$];
    w_exp_t  w_q[$];
    int      n_checks = 0;
    int      n_fail = 0;
    int      step_no = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL step %0d %s: got %h expected %h", step_no, nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue expected channel contents, then
    // compare outputs mid-cycle and drain the scoreboard on handshakes.
    task automatic step(input row_t r);
        ar_exp_t a;
        aw_exp_t aw;
        w_exp_t  w;
        @(posedge clk);
        #1;
        reset    = r.rst;
        inst_req = r.ireq;
        data_req = r.dreq;
        data_wr  = r.dwr;
        data_size = r.dsize;
        data_addr = r.daddr;
        arready  = r.arready;
        rvalid   = r.rvalid;
        rid      = r.rid;
        rdata    = r.rdata;
        awready  = r.awready;
        wready   = r.wready;
        bvalid   = r.bvalid;
        if (r.e_iaok) begin
            a.id = ID_INST; a.addr = IADDR; a.size = 3'd2;
            ar_q.push_back(a);
        end
        if (r.e_daok && !r.dwr) begin
            a.id = ID_DATA; a.addr = r.daddr; a.size = {1'b0, r.dsize};
            ar_q.push_back(a);
        end
        if (r.e_daok && r.dwr) begin
            aw.addr = r.daddr; aw.size = {1'b0, r.dsize};
            aw_q.push_back(aw);
            w.data = WDATA; w.strb = WSTRB;
            w_q.push_back(w);
        end
        @(negedge clk);
        chk("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, r.e_iaok});
        chk("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, r.e_daok});
        chk("arvalid",      {31'd0, arvalid},      {31'd0, r.e_arvalid});
        chk("rready",       {31'd0, rready},       {31'd0, r.e_rready});
        chk("inst_data_ok", {31'd0, inst_data_ok}, {31'd0, r.e_idok});
        chk("data_data_ok", {31'd0, data_data_ok}, {31'd0, r.e_ddok});
        chk("awvalid",      {31'd0, awvalid},      {31'd0, r.e_awvalid});
        chk("wvalid",       {31'd0, wvalid},       {31'd0, r.e_wvalid});
        chk("bready",       {31'd0, bready},       {31'd0, r.e_bready});
        if (r.e_idok) chk("inst_rdata", inst_rdata, r.rdata);
        if (r.e_ddok && r.rvalid) chk("data_rdata", data_rdata, r.rdata);
        if (arvalid && arready) begin
            if (ar_q.size() == 0) chk("ar_unexpected", 32'd1, 32'd0);
            else begin
                a = ar_q.pop_front();
                chk("arid",   {28'd0, arid},   {28'd0, a.id});
                chk("araddr", araddr,          a.addr);
                chk("arsize", {29'd0, arsize}, {29'd0, a.size});
            end
        end
        if (awvalid && awready) begin
            if (aw_q.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
            else begin
                aw = aw_q.pop_front();
                chk("awaddr", awaddr,          aw.addr);
                chk("awsize", {29'd0, awsize}, {29'd0, aw.size});
                chk("awid",   {28'd0, awid},   {28'd0, ID_DATA});
            end
        end
        if (wvalid && wready) begin
            if (w_q.size() == 0) chk("w_unexpected", 32'd1, 32'd0);
            else begin
                w = w_q.pop_front();
                chk("wdata", wdata,          w.data);
                chk("wstrb", {28'd0, wstrb}, {28'd0, w.strb});
            end
        end
        step_no++;
    endtask

    initial begin
        row_t r;

        // Reset with requests pending: no addr_ok while reset is high.
        r = '0; r.rst = 1; r.ireq = 1; r.dreq = 1; r.dwr = 1; tbl.push_back(r);
        r = '0; r.rst = 1; r.ireq = 1; tbl.push_back(r);

        // Fetch: addr_ok @0, arvalid @1, data_ok @3.
        r = '0; r.ireq = 1; r.e_iaok = 1; tbl.push_back(r);
        r = '0; r.arready = 1; r.e_arvalid = 1; tbl.push_back(r);
        r = '0; r.e_rready = 1; tbl.push_back(r);
        r = '0; r.rvalid = 1; r.rid = ID_INST; r.rdata = 32'h0280_0000;
        r.e_rready = 1; r.e_idok = 1; tbl.push_back(r);
        // rvalid in R_IDLE is ignored.
        r = '0; r.rvalid = 1; r.rid = ID_INST; r.rdata = 32'h0280_0000; tbl.push_back(r);

        // Data read beats a concurrent fetch; fetch accepted after return.
        r = '0; r.ireq = 1; r.dreq = 1; r.daddr = 32'h100; r.dsize = 2'd1; r.e_daok = 1; tbl.push_back(r);
        r = '0; r.ireq = 1; r.arready = 1; r.e_arvalid = 1; tbl.push_back(r);
        r = '0; r.ireq = 1; r.rvalid = 1; r.rid = ID_DATA; r.rdata = 32'hdead_beef;
        r.e_rready = 1; r.e_ddok = 1; tbl.push_back(r);
        r = '0; r.ireq = 1; r.e_iaok = 1; tbl.push_back(r);
        r = '0; r.arready = 1; r.e_arvalid = 1; tbl.push_back(r);
        r = '0; r.rvalid = 1; r.rid = ID_INST; r.rdata = 32'h1111_1111;
        r.e_rready = 1; r.e_idok = 1; tbl.push_back(r);

        // Write with awready two cycles before wready; fetch runs alongside.
        r = '0; r.dreq = 1; r.dwr = 1; r.dsize = 2'd2; r.daddr = 32'h200; r.e_daok = 1; tbl.push_back(r);
        r = '0; r.ireq = 1; r.awready = 1; r.e_iaok = 1; r.e_awvalid = 1; r.e_wvalid = 1; tbl.push_back(r);
        r = '0; r.arready = 1; r.e_arvalid = 1; r.e_wvalid = 1; tbl.push_back(r);
        r = '0; r.wready = 1; r.e_rready = 1; r.e_wvalid = 1; tbl.push_back(r);
        r = '0; r.rvalid = 1; r.rid = ID_INST; r.rdata = 32'h2222_3333;
        r.e_rready = 1; r.e_idok = 1; r.e_bready = 1; tbl.push_back(r);
        r = '0; r.bvalid = 1; r.e_bready = 1; r.e_ddok = 1; tbl.push_back(r);

        // Data read return collides with bvalid: read first, write next cycle.
        r = '0; r.dreq = 1; r.dwr = 1; r.dsize = 2'd2; r.daddr = 32'h300; r.e_daok = 1; tbl.push_back(r);
        r = '0; r.dreq = 1; r.dsize = 2'd2; r.daddr = 32'h400; r.awready = 1; r.wready = 1;
        r.e_daok = 1; r.e_awvalid = 1; r.e_wvalid = 1; tbl.push_back(r);
        r = '0; r.arready = 1; r.e_arvalid = 1; r.e_bready = 1; tbl.push_back(r);
        r = '0; r.rvalid = 1; r.rid = ID_DATA; r.rdata = 32'hcafe_f00d; r.bvalid = 1;
        r.e_rready = 1; r.e_ddok = 1; tbl.push_back(r);
        r = '0; r.bvalid = 1; r.e_bready = 1; r.e_ddok = 1; tbl.push_back(r);
        // bvalid in W_IDLE is ignored.
        r = '0; r.bvalid = 1; tbl.push_back(r);

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Read-after-write to the same word.
        r = '0; r.dreq = 1; r.dwr = 1; r.dsize = 2'd2; r.daddr = 32'h80; r.e_daok = 1; step(r);
        r = '0; r.awready = 1; r.wready = 1; r.e_awvalid = 1; r.e_wvalid = 1; step(r);
`ifdef RAW_CHECK_EN
        r = '0; r.ireq = 1; r.dreq = 1; r.dsize = 2'd2; r.daddr = 32'h80; r.e_bready = 1; step(r);
        r = '0; r.ireq = 1; r.dreq = 1; r.dsize = 2'd2; r.daddr = 32'h80; r.bvalid = 1;
        r.e_bready = 1; r.e_ddok = 1; step(r);
        r = '0; r.ireq = 1; r.dreq = 1; r.dsize = 2'd2; r.daddr = 32'h80; r.e_daok = 1; step(r);
        r = '0; r.arready = 1; r.e_arvalid = 1; step(r);
        r = '0; r.rvalid = 1; r.rid = ID_DATA; r.rdata = 32'h5555_aaaa; r.e_rready = 1; r.e_ddok = 1; step(r);
`else
        r = '0; r.ireq = 1; r.dreq = 1; r.dsize = 2'd2; r.daddr = 32'h80; r.e_bready = 1; r.e_daok = 1; step(r);
        r = '0; r.bvalid = 1; r.arready = 1; r.e_bready = 1; r.e_ddok = 1; r.e_arvalid = 1; step(r);
        r = '0; r.rvalid = 1; r.rid = ID_DATA; r.rdata = 32'h5555_aaaa; r.e_rready = 1; r.e_ddok = 1; step(r);
`endif

        // Reset in R_DATA with a write stuck in W_REQ abandons both.
        r = '0; r.ireq = 1; r.dreq = 1; r.dwr = 1; r.dsize = 2'd2; r.daddr = 32'h500;
        r.e_iaok = 1; r.e_daok = 1; step(r);
        r = '0; r.arready = 1; r.e_arvalid = 1; r.e_awvalid = 1; r.e_wvalid = 1; step(r);
        r = '0; r.e_rready = 1; r.e_awvalid = 1; r.e_wvalid = 1; step(r);
        r = '0; r.rst = 1; r.ireq = 1; step(r);
        aw_q.delete();
        w_q.delete();
        ar_q.delete();
        r = '0; r.rvalid = 1; r.rid = ID_INST; r.bvalid = 1; r.awready = 1; r.wready = 1; step(r);
        r = '0; r.ireq = 1; r.e_iaok = 1; step(r);
        r = '0; r.arready = 1; r.e_arvalid = 1; step(r);
        r = '0; r.rvalid = 1; r.rid = ID_INST; r.rdata = 32'h7777_0000; r.e_rready = 1; r.e_idok = 1; step(r);

        chk("ar_queue_drained", ar_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
